pong_engine: RTL and testbench

- Parametrised two-player pong game core. Owns ball position and velocity, both paddle positions, wall and paddle collision resolution, scoring and the serve/play/game-over sequencing.
- Advances one step per frame_tick pulse.
- Sits between the debounced player inputs and the video/score display logic, replacing fixed-size hand-wired ball/paddle/collision glue.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_paddle_ctrl.sv | 52 +++++
 rtl/pong_engine.sv | 213 +++++++++++++++++++++
 tb/tb_pong_engine.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings and types for the pong game core.
package pong_pkg;

   // Game state encodings (2-bit, legacy-compatible constants)
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_SERVE     = 2'd1;
   localparam state_t ST_PLAY      = 2'd2;
   localparam state_t ST_GAME_OVER = 2'd3;

   // Winner encodings
   typedef logic [1:0] winner_t;
   localparam winner_t WIN_NONE = 2'd0;
   localparam winner_t WIN_P1   = 2'd1;
   localparam winner_t WIN_P2   = 2'd2;

   // Signed coordinate: two extra bits so x+v / y+v never wraps.
   // Sized for the default 10-bit coordinate width.
   localparam int DEF_COORD_W = 10;
   typedef logic signed [DEF_COORD_W+1:0] scoord_t;

endpackage

// File: rtl/pong_paddle_ctrl.sv
// One player's paddle: saturating y register driven by up/dn buttons.
module pong_paddle_ctrl
   import pong_pkg::*;
#(
   parameter int COORD_W      = 10,
   parameter int FIELD_H      = 480,
   parameter int PADDLE_R     = 32,
   parameter int PADDLE_SPEED = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic               recentre,
   input  logic               up,
   input  logic               dn,
   output logic [COORD_W-1:0] y
);

   localparam int SW = COORD_W + 2;
   localparam logic signed [SW-1:0] Y_MIN = SW'(PADDLE_R);
   localparam logic signed [SW-1:0] Y_MAX = SW'(FIELD_H - 1 - PADDLE_R);
   localparam logic signed [SW-1:0] STEP  = SW'(PADDLE_SPEED);
   localparam logic [COORD_W-1:0]   Y_CTR = COORD_W'(FIELD_H / 2);

   logic signed [SW-1:0] cur, mv, nxt;

   // Candidate move (both/neither pressed holds), then clamp to the field
   always_comb begin
      cur = $signed({2'b00, y});
      mv  = cur;
      if (up && !dn)
         mv = cur - STEP;
      else if (dn && !up)
         mv = cur + STEP;
      nxt = mv;
      if (mv < Y_MIN)
         nxt = Y_MIN;
      else if (mv > Y_MAX)
         nxt = Y_MAX;
   end

   // Paddle register: recentre has priority over a normal move
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         y <= Y_CTR;
      else if (recentre)
         y <= Y_CTR;
      else if (enable)
         y <= COORD_W'(nxt);
   end

endmodule

// File: rtl/pong_engine.sv
// Two-player pong core: ball motion, collisions, scoring and game sequencing.
// All game state advances only on frame_tick; event pulses are registered.
module pong_engine
   import pong_pkg::*;
#(
   parameter int COORD_W      = 10,
   parameter int FIELD_W      = 640,
   parameter int FIELD_H      = 480,
   parameter int BALL_R       = 4,
   parameter int PADDLE_R     = 32,
   parameter int P1_X         = 50,
   parameter int P2_X         = 590,
   parameter int BALL_SPEED   = 2,
   parameter int PADDLE_SPEED = 4,
   parameter int WIN_SCORE    = 7,
   parameter int SCORE_W      = 4,
   parameter int SERVE_DELAY  = 60
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic               p1_up,
   input  logic               p1_dn,
   input  logic               p2_up,
   input  logic               p2_dn,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [COORD_W-1:0] p1_y,
   output logic [COORD_W-1:0] p2_y,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic [1:0]         state,
   output logic [1:0]         winner,
   output logic               wall_hit,
   output logic               paddle_hit,
   output logic               point
);

   localparam int SW    = COORD_W + 2;
   localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

   localparam logic [COORD_W-1:0]   CX     = COORD_W'(FIELD_W / 2);
   localparam logic [COORD_W-1:0]   CY     = COORD_W'(FIELD_H / 2);
   localparam logic signed [SW-1:0] SPD    = SW'(BALL_SPEED);
   localparam logic signed [SW-1:0] Y_TOP  = SW'(BALL_R);
   localparam logic signed [SW-1:0] Y_BOT  = SW'(FIELD_H - 1 - BALL_R);
   localparam logic signed [SW-1:0] X_L    = SW'(P1_X + BALL_R);
   localparam logic signed [SW-1:0] X_R    = SW'(P2_X - BALL_R);
   localparam logic signed [SW-1:0] X_GL   = SW'(BALL_R);
   localparam logic signed [SW-1:0] X_GR   = SW'(FIELD_W - 1 - BALL_R);
   localparam logic signed [SW-1:0] REACH  = SW'(PADDLE_R + BALL_R);
   localparam logic [SCORE_W-1:0]   WIN_S  = SCORE_W'(WIN_SCORE);
   localparam logic [CNT_W-1:0]     S_LOAD = CNT_W'(SERVE_DELAY);
   localparam logic [CNT_W-1:0]     S_ONE  = CNT_W'(1);

   // Velocity magnitudes are fixed; only the signs are state
   logic             vx_neg, vy_neg;
   logic [CNT_W-1:0] serve_cnt;

   logic paddle_en, paddle_rc;

   assign paddle_en = frame_tick && (state == ST_SERVE || state == ST_PLAY);
   assign paddle_rc = frame_tick && (state == ST_GAME_OVER) && start;

   pong_paddle_ctrl #(
      .COORD_W(COORD_W), .FIELD_H(FIELD_H),
      .PADDLE_R(PADDLE_R), .PADDLE_SPEED(PADDLE_SPEED)
   ) u_p1 (
      .clk(clk), .rst(rst), .enable(paddle_en), .recentre(paddle_rc),
      .up(p1_up), .dn(p1_dn), .y(p1_y)
   );

   pong_paddle_ctrl #(
      .COORD_W(COORD_W), .FIELD_H(FIELD_H),
      .PADDLE_R(PADDLE_R), .PADDLE_SPEED(PADDLE_SPEED)
   ) u_p2 (
      .clk(clk), .rst(rst), .enable(paddle_en), .recentre(paddle_rc),
      .up(p2_up), .dn(p2_dn), .y(p2_y)
   );

   logic signed [SW-1:0] bx, by, nx, ny, p1s, p2s, d1, d2, a1, a2;
   logic signed [SW-1:0] nx_res, ny_res;
   logic                 top_hit, bot_hit, hit_l, hit_r, goal_l, goal_r;
   logic [SCORE_W-1:0]   s1_next, s2_next;

   // Next ball position and collision/goal classification; paddle y used
   // here is the value registered before this tick
   always_comb begin
      bx  = $signed({2'b00, ball_x});
      by  = $signed({2'b00, ball_y});
      p1s = $signed({2'b00, p1_y});
      p2s = $signed({2'b00, p2_y});
      nx  = vx_neg ? (bx - SPD) : (bx + SPD);
      ny  = vy_neg ? (by - SPD) : (by + SPD);
      d1  = ny - p1s;
      d2  = ny - p2s;
      a1  = d1[SW-1] ? -d1 : d1;
      a2  = d2[SW-1] ? -d2 : d2;

      top_hit = (ny <= Y_TOP);
      bot_hit = (ny >= Y_BOT);
      hit_l   = vx_neg  && (bx > X_L) && (nx <= X_L) && (a1 <= REACH);
      hit_r   = !vx_neg && (bx < X_R) && (nx >= X_R) && (a2 <= REACH);
      goal_l  = !hit_l && !hit_r && (nx <= X_GL);
      goal_r  = !hit_l && !hit_r && (nx >= X_GR);

      ny_res = top_hit ? Y_TOP : (bot_hit ? Y_BOT : ny);
      nx_res = hit_l ? X_L : (hit_r ? X_R : nx);

      // Scores saturate at the winning value
      s1_next = (score1 == WIN_S) ? score1 : score1 + SCORE_W'(1);
      s2_next = (score2 == WIN_S) ? score2 : score2 + SCORE_W'(1);
   end

   // Game FSM, ball, velocity, scores and event pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ball_x     <= CX;
         ball_y     <= CY;
         vx_neg     <= 1'b0;
         vy_neg     <= 1'b0;
         score1     <= '0;
         score2     <= '0;
         winner     <= WIN_NONE;
         serve_cnt  <= '0;
         wall_hit   <= 1'b0;
         paddle_hit <= 1'b0;
         point      <= 1'b0;
      end else begin
         wall_hit   <= 1'b0;
         paddle_hit <= 1'b0;
         point      <= 1'b0;
         if (frame_tick) begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state     <= ST_SERVE;
                     serve_cnt <= S_LOAD;
                  end
               end
               ST_SERVE: begin
                  ball_x <= CX;
                  ball_y <= CY;
                  if (serve_cnt <= S_ONE) begin
                     state     <= ST_PLAY;
                     serve_cnt <= '0;
                  end else begin
                     serve_cnt <= serve_cnt - S_ONE;
                  end
               end
               ST_PLAY: begin
                  if (goal_l || goal_r) begin
                     // A point overrides any wall bounce on the same tick;
                     // vy keeps its pre-tick sign
                     point     <= 1'b1;
                     ball_x    <= CX;
                     ball_y    <= CY;
                     serve_cnt <= S_LOAD;
                     if (goal_r) begin
                        // P1 scored: next serve travels leftward
                        score1 <= s1_next;
                        vx_neg <= 1'b1;
                        if (s1_next == WIN_S) begin
                           winner <= WIN_P1;
                           state  <= ST_GAME_OVER;
                        end else begin
                           state  <= ST_SERVE;
                        end
                     end else begin
                        // P2 scored: next serve travels rightward
                        score2 <= s2_next;
                        vx_neg <= 1'b0;
                        if (s2_next == WIN_S) begin
                           winner <= WIN_P2;
                           state  <= ST_GAME_OVER;
                        end else begin
                           state  <= ST_SERVE;
                        end
                     end
                  end else begin
                     ball_x     <= COORD_W'(nx_res);
                     ball_y     <= COORD_W'(ny_res);
                     wall_hit   <= top_hit || bot_hit;
                     paddle_hit <= hit_l || hit_r;
                     if (top_hit)
                        vy_neg <= 1'b0;
                     else if (bot_hit)
                        vy_neg <= 1'b1;
                     if (hit_l)
                        vx_neg <= 1'b0;
                     else if (hit_r)
                        vx_neg <= 1'b1;
                  end
               end
               default: begin
                  if (start) begin
                     score1    <= '0;
                     score2    <= '0;
                     winner    <= WIN_NONE;
                     ball_x    <= CX;
                     ball_y    <= CY;
                     state     <= ST_SERVE;
                     serve_cnt <= S_LOAD;
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pong_engine.sv
// Directed self-checking bench for pong_engine (SERVE_DELAY=2, WIN_SCORE=2).
module tb_pong_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0, start = 1'b0;
   logic       p1_up = 1'b0, p1_dn = 1'b0, p2_up = 1'b0, p2_dn = 1'b0;
   logic [9:0] ball_x, ball_y, p1_y, p2_y;
   logic [3:0] score1, score2;
   logic [1:0] state, winner;
   logic       wall_hit, paddle_hit, point;

   int errors = 0;
   int checks = 0;
   int k, ph;

   typedef struct {
      int   n;
      logic p1u, p1d, p2u, p2d;
      int   st, bx, by, py1, py2;
   } vec_t;

   vec_t tbl [0:4];

   pong_engine #(.SERVE_DELAY(2), .WIN_SCORE(2)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
      .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
      .score1(score1), .score2(score2), .state(state), .winner(winner),
      .wall_hit(wall_hit), .paddle_hit(paddle_hit), .point(point)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, " ball_x"}, ball_x, 320);
      chk({tag, " ball_y"}, ball_y, 240);
      chk({tag, " p1_y"}, p1_y, 240);
      chk({tag, " p2_y"}, p2_y, 240);
      chk({tag, " scores"}, {score1, score2}, 0);
      chk({tag, " state"}, state, 0);
      chk({tag, " winner"}, winner, 0);
      chk({tag, " pulses"}, {wall_hit, paddle_hit, point}, 0);
   endtask

   initial begin
      // n, p1u,p1d,p2u,p2d, state, ball_x, ball_y, p1_y, p2_y
      tbl[0] = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 2, 320, 240, 232, 240};
      tbl[1] = '{50, 1'b1, 1'b0, 1'b0, 1'b0, 2, 420, 340, 32,  240};
      tbl[2] = '{48, 1'b1, 1'b0, 1'b0, 1'b0, 2, 516, 436, 32,  240};
      tbl[3] = '{10, 1'b1, 1'b1, 1'b0, 1'b0, 2, 536, 456, 32,  240};
      tbl[4] = '{9,  1'b0, 1'b0, 1'b0, 1'b0, 2, 554, 474, 32,  240};

      repeat (3) @(negedge clk);
      check_reset_state("por");
      rst = 1'b1;

      // Ticks in IDLE do nothing, even with buttons held
      p1_up = 1'b1;
      ticks(3);
      chk("idle state", state, 0);
      chk("idle p1_y", p1_y, 240);
      p1_up = 1'b0;

      // ---- Run 1: clamp, wall bounce, miss/score, win ----
      start_game();
      chk("start state", state, 1);
      for (int i = 0; i < 5; i++) begin
         p1_up = tbl[i].p1u; p1_dn = tbl[i].p1d;
         p2_up = tbl[i].p2u; p2_dn = tbl[i].p2d;
         ticks(tbl[i].n);
         chk($sformatf("row%0d state", i), state, tbl[i].st);
         chk($sformatf("row%0d ball_x", i), ball_x, tbl[i].bx);
         chk($sformatf("row%0d ball_y", i), ball_y, tbl[i].by);
         chk($sformatf("row%0d p1_y", i), p1_y, tbl[i].py1);
         chk($sformatf("row%0d p2_y", i), p2_y, tbl[i].py2);
      end

      // PLAY tick 118: bottom wall
      tick();
      chk("wall ball_y", ball_y, 475);
      chk("wall ball_x", ball_x, 556);
      chk("wall pulse", wall_hit, 1);
      @(negedge clk);
      chk("wall pulse width", wall_hit, 0);
      tick();
      chk("wall vy neg", ball_y, 473);

      // PLAY tick 157, then the goal on 158
      ticks(38);
      chk("pre-goal ball_x", ball_x, 634);
      chk("pre-goal point", point, 0);
      tick();
      chk("goal point", point, 1);
      chk("goal wall", wall_hit, 0);
      chk("goal score1", score1, 1);
      chk("goal score2", score2, 0);
      chk("goal state", state, 1);
      chk("goal ball_x", ball_x, 320);
      chk("goal ball_y", ball_y, 240);
      @(negedge clk);
      chk("point pulse width", point, 0);

      // Serve then first play tick shows vx=-2, vy still negative
      p1_up = 1'b1;
      ticks(2);
      chk("reserve state", state, 2);
      tick();
      chk("serve vx", ball_x, 318);
      chk("serve vy", ball_y, 238);

      // Rally 2: P1 returns off its clamped paddle, P2 misses
      k = 1; ph = 0;
      while (point !== 1'b1 && k < 600) begin
         tick();
         k++;
         if (paddle_hit) ph = k;
      end
      chk("rally2 paddle tick", ph, 133);
      chk("rally2 point tick", k, 424);
      chk("win score1", score1, 2);
      chk("win winner", winner, 1);
      chk("win state", state, 3);
      chk("win ball_x", ball_x, 320);

      // GAME_OVER is frozen
      p1_dn = 1'b0; p1_up = 1'b0; p2_dn = 1'b1;
      ticks(2);
      chk("over state", state, 3);
      chk("over winner", winner, 1);
      chk("over p2_y", p2_y, 240);
      chk("over pulses", {wall_hit, paddle_hit, point}, 0);
      p2_dn = 1'b0;
      start_game();
      chk("restart scores", {score1, score2}, 0);
      chk("restart winner", winner, 0);
      chk("restart state", state, 1);
      chk("restart p1_y", p1_y, 240);

      // ---- Run 2: right paddle hit, P2 scores, async reset ----
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("rst2");
      rst = 1'b1;
      p2_dn = 1'b1;
      start_game();
      ticks(2 + 132);
      chk("ph p2_y", p2_y, 447);
      chk("ph pre ball_x", ball_x, 584);
      chk("ph pre ball_y", ball_y, 447);
      tick();
      chk("ph pulse", paddle_hit, 1);
      chk("ph wall", wall_hit, 0);
      chk("ph ball_x", ball_x, 586);
      chk("ph ball_y", ball_y, 445);
      @(negedge clk);
      chk("ph pulse width", paddle_hit, 0);
      tick();
      chk("ph vx", ball_x, 584);

      k = 134;
      while (point !== 1'b1 && k < 600) begin
         tick();
         k++;
      end
      chk("p2 point tick", k, 424);
      chk("p2 score2", score2, 1);
      chk("p2 score1", score1, 0);
      chk("p2 state", state, 1);
      ticks(3);
      chk("p2 serve vx", ball_x, 322);
      chk("mid-play state", state, 2);

      // Asynchronous reset between clock edges
      @(negedge clk);
      #1 rst = 1'b0;
      #1 check_reset_state("async");
      @(negedge clk);
      rst = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
